// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, NOP encoding and FSM state type for the
// instruction fetch stage.
package fetch_pkg;

  localparam int unsigned WORD_LENGTH_DEF   = 16;
  localparam int unsigned ADDRESS_SPACE_DEF = 21;
  localparam int unsigned IMM_FLAG_BIT_DEF  = 15;

  // Bubble opcode written into IF/ID on flush/branch.
  localparam logic [WORD_LENGTH_DEF-1:0] NOP = '0;

  typedef enum logic {
    S_OP  = 1'b0,  // fetching an opcode word
    S_IMM = 1'b1   // fetching the immediate word of a two-word instruction
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with stall/flush control.
//   clk_i, reset_i : clock, synchronous active-high reset
//   stall_i        : hold every output
//   flush_i        : write a bubble (wins over stall)
//   kill_i         : fetch redirect; write a bubble regardless of stall
//   load_i         : a complete instruction is presented this cycle
//   instr_i/imm_i/pc_i : instruction fields to capture on load
//   instr_o/imm_o/pc_o/valid_o : registered IF/ID contents
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned WORD_LENGTH   = WORD_LENGTH_DEF,
  parameter int unsigned ADDRESS_SPACE = ADDRESS_SPACE_DEF
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     kill_i,
  input  logic                     load_i,
  input  logic [WORD_LENGTH-1:0]   instr_i,
  input  logic [WORD_LENGTH-1:0]   imm_i,
  input  logic [ADDRESS_SPACE-1:0] pc_i,
  output logic [WORD_LENGTH-1:0]   instr_o,
  output logic [WORD_LENGTH-1:0]   imm_o,
  output logic [ADDRESS_SPACE-1:0] pc_o,
  output logic                     valid_o
);

  logic [WORD_LENGTH-1:0]   instr_q;
  logic [WORD_LENGTH-1:0]   imm_q;
  logic [ADDRESS_SPACE-1:0] pc_q;
  logic                     valid_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instr_q <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (kill_i || flush_i) begin
      // Bubble; the pc field is left as-is since a bubble carries no address.
      instr_q <= WORD_LENGTH'(NOP);
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        instr_q <= instr_i;
        imm_q   <= imm_i;
        pc_q    <= pc_i;
        valid_q <= 1'b1;
      end else begin
        // Opcode of a two-word instruction is being held: nothing to issue.
        valid_q <= 1'b0;
      end
    end
  end

  assign instr_o = instr_q;
  assign imm_o   = imm_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one- and two-word instructions.
//   clk, reset      : clock, synchronous active-high reset
//   mar             : instruction address (the PC register)
//   mdr             : memory word at mar, sampled on the next posedge
//   stall           : hold PC, FSM and IF/ID
//   flush           : replace IF/ID contents with a bubble
//   branch_taken/branch_target : redirect fetch
//   if_id_instr/if_id_imm/if_id_pc/if_id_valid : IF/ID outputs
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned               WORD_LENGTH   = WORD_LENGTH_DEF,
  parameter int unsigned               ADDRESS_SPACE = ADDRESS_SPACE_DEF,
  parameter logic [ADDRESS_SPACE-1:0]  RESET_PC      = '0,
  parameter int unsigned               IMM_FLAG_BIT  = IMM_FLAG_BIT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_SPACE-1:0] mar,
  input  logic [WORD_LENGTH-1:0]   mdr,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     branch_taken,
  input  logic [ADDRESS_SPACE-1:0] branch_target,
  output logic [WORD_LENGTH-1:0]   if_id_instr,
  output logic [WORD_LENGTH-1:0]   if_id_imm,
  output logic [ADDRESS_SPACE-1:0] if_id_pc,
  output logic                     if_id_valid
);

  logic [ADDRESS_SPACE-1:0] pc_q, pc_d, pc_inc;
  fetch_state_e             state_q, state_d;
  logic [WORD_LENGTH-1:0]   hold_q, hold_d;

  logic                     load;
  logic [WORD_LENGTH-1:0]   instr_n;
  logic [WORD_LENGTH-1:0]   imm_n;

  // Natural overflow of the fixed-width add gives the modulo wrap.
  assign pc_inc = pc_q + ADDRESS_SPACE'(1);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    hold_d  = hold_q;
    load    = 1'b0;
    instr_n = mdr;
    imm_n   = '0;
    if (branch_taken) begin
      pc_d    = branch_target;
      state_d = S_OP;
      hold_d  = '0;
    end else if (!stall) begin
      pc_d = pc_inc;
      case (state_q)
        S_OP: begin
          if (mdr[IMM_FLAG_BIT]) begin
            hold_d  = mdr;
            state_d = S_IMM;
          end else begin
            load = 1'b1;
          end
        end
        S_IMM: begin
          load    = 1'b1;
          instr_n = hold_q;
          imm_n   = mdr;
          state_d = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= S_OP;
      hold_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign mar = pc_q;

  if_id_reg #(
    .WORD_LENGTH  (WORD_LENGTH),
    .ADDRESS_SPACE(ADDRESS_SPACE)
  ) u_if_id (
    .clk_i   (clk),
    .reset_i (reset),
    .stall_i (stall),
    .flush_i (flush),
    .kill_i  (branch_taken),
    .load_i  (load),
    .instr_i (instr_n),
    .imm_i   (imm_n),
    .pc_i    (pc_inc),
    .instr_o (if_id_instr),
    .imm_o   (if_id_imm),
    .pc_o    (if_id_pc),
    .valid_o (if_id_valid)
  );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16, instruction word width.
REQ-002 SHALL have parameter ADDRESS_SPACE, default 21, instruction address width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have parameter IMM_FLAG_BIT, default 15; mdr bit that marks a two-word instruction.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port mar, output, ADDRESS_SPACE, instruction memory address; equals the PC register.
REQ-008 SHALL have port mdr, input, WORD_LENGTH, memory word for the current mar, sampled at the next posedge.
REQ-009 SHALL have port stall, input, 1, hold PC, FSM and IF/ID outputs.
REQ-010 SHALL have port flush, input, 1, replace the IF/ID contents with a bubble.
REQ-011 SHALL have port branch_taken, input, 1, redirect fetch.
REQ-012 SHALL have port branch_target, input, ADDRESS_SPACE, redirect address.
REQ-013 SHALL have port if_id_instr, output, WORD_LENGTH, registered opcode word.
REQ-014 SHALL have port if_id_imm, output, WORD_LENGTH, registered immediate word; 0 for one-word instructions.
REQ-015 SHALL have port if_id_pc, output, ADDRESS_SPACE, address following the last word of the instruction.
REQ-016 SHALL have port if_id_valid, output, 1, IF/ID holds a real instruction.

Function
REQ-017 SHALL implement a two-state FSM, S_OP (fetch opcode word) and S_IMM (fetch immediate word).
REQ-018 In S_OP with no stall or branch, SHALL advance the PC by 1.
REQ-019 In S_OP, when mdr[IMM_FLAG_BIT]=0, SHALL load if_id_instr=mdr, if_id_imm=0, if_id_pc=PC+1, if_id_valid=1 at the same edge.
REQ-020 In S_OP, when mdr[IMM_FLAG_BIT]=1, SHALL latch mdr into an internal opcode hold register, set if_id_valid=0 and go to S_IMM.
REQ-021 In S_IMM, SHALL load if_id_instr=held opcode, if_id_imm=mdr, if_id_pc=PC+1 and if_id_valid=1, advance the PC and return to S_OP.
REQ-022 Fetch throughput SHALL be one word per cycle; a two-word instruction SHALL appear on IF/ID exactly one cycle after a one-word one would.
REQ-023 PC increment SHALL be modulo 2^ADDRESS_SPACE; all-ones SHALL wrap to 0.
REQ-024 Priority SHALL be reset > branch_taken > stall > normal fetch.
REQ-025 On branch_taken, SHALL set PC=branch_target and FSM=S_OP, discard any held opcode and set if_id_valid=0, regardless of stall or current state.
REQ-026 On stall without branch_taken, SHALL hold PC, FSM state, the hold register and all IF/ID outputs unchanged.
REQ-027 On flush, SHALL set if_id_instr=0, if_id_imm=0 and if_id_valid=0 at that edge; PC and FSM SHALL follow the stall/branch rules unchanged.
REQ-028 On flush with stall, the bubble SHALL be written and the PC held.
REQ-029 On flush arriving in S_IMM, SHALL insert the bubble and still complete the immediate fetch on the following cycles.
REQ-030 mar SHALL be driven combinationally from the PC register only, with no path from mdr or any input to mar.

Reset
REQ-031 On reset high at posedge, SHALL set PC=RESET_PC, FSM=S_OP, hold register=0, if_id_instr=0, if_id_imm=0, if_id_pc=0 and if_id_valid=0.
REQ-032 SHALL ignore mdr, which may be X/Z, during the reset cycle.
REQ-033 Reset asserted mid-instruction (S_IMM) SHALL abandon the instruction with no IF/ID output.

Structure
REQ-034 Package fetch_pkg SHALL hold WORD_LENGTH/ADDRESS_SPACE defaults, NOP encoding (0), IMM_FLAG_BIT and the FSM state enum {S_OP, S_IMM}.
REQ-035 The IF/ID output register with stall/flush control SHALL be sub-module if_id_reg; PC and FSM logic SHALL live in fetch_stage.

Verification
REQ-036 Reset, then memory words 0x0001,0x0002 at 0,1 -> mar 0,1,2; IF/ID valid with instr 0x0001/pc 1, then 0x0002/pc 2.
REQ-037 Word 0x8005 at 0 followed by 0x1234 -> one bubble cycle, then instr 0x8005, imm 0x1234, pc 2, valid=1.
REQ-038 stall high for 3 cycles mid-stream -> mar and IF/ID constant for 3 cycles, then fetch resumes with no lost or repeated word.
REQ-039 branch_taken with target 0x00100 asserted while in S_IMM, with stall also high -> next mar=0x00100, if_id_valid=0, held opcode never emitted.
REQ-040 PC at 0x1FFFFF with a one-word instruction -> if_id_pc=0 and next mar=0; flush with stall -> bubble written, mar held.
